// File: rtl/mem_wb_pkg.sv
// Shared defines for the MEM/WB stage: enables, bus widths, stall vector.
// Imported by the pipeline register and the LLbit register.
package mem_wb_pkg;

    localparam logic RstEnable    = 1'b1;
    localparam logic WriteEnable  = 1'b1;
    localparam logic WriteDisable = 1'b0;
    localparam logic Stop         = 1'b1;
    localparam logic NoStop       = 1'b0;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int STALL_W    = 6;

    localparam int STALL_MEM = 4;
    localparam int STALL_WB  = 5;

    typedef logic [REG_ADDR_W-1:0] RegAddrBus;
    typedef logic [REG_DATA_W-1:0] RegBus;

    localparam RegBus ZeroWord = '0;

endpackage

// File: rtl/mem_wb_llbit_reg.sv
// LLbit register for ll/sc plus the forwarding mux toward the MEM stage.
// A pending write is bypassed to llbit_o until it commits.
module llbit_reg
    import mem_wb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic commit_en,
    input  logic pend_we,
    input  logic pend_value,
    output logic llbit_o
);

    logic llbit_q;
    logic llbit_d;

    always_comb begin
        llbit_d = llbit_q;
        if (flush) begin
            llbit_d = 1'b0;
        end else if (commit_en && pend_we == WriteEnable) begin
            llbit_d = pend_value;
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            llbit_q <= 1'b0;
        end else begin
            llbit_q <= llbit_d;
        end
    end

    always_comb begin
        llbit_o = llbit_q;
        if (flush) begin
            llbit_o = 1'b0;
        end else if (pend_we == WriteEnable) begin
            llbit_o = pend_value;
        end
    end

endmodule

// File: rtl/mem_wb.sv
// MEM/WB pipeline register: drives regfile and HI/LO write ports,
// carries the pending LLbit request and owns the LLbit register.
module mem_wb
    import mem_wb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic [ADDR_W-1:0]  mem_waddr,
    input  logic               mem_we,
    input  logic [DATA_W-1:0]  mem_wdata,
    input  logic [DATA_W-1:0]  mem_hi,
    input  logic [DATA_W-1:0]  mem_lo,
    input  logic               mem_whilo,
    input  logic               mem_llbit_we,
    input  logic               mem_llbit_value,
    output logic [ADDR_W-1:0]  wb_waddr,
    output logic               wb_we,
    output logic [DATA_W-1:0]  wb_wdata,
    output logic [DATA_W-1:0]  wb_hi,
    output logic [DATA_W-1:0]  wb_lo,
    output logic               wb_whilo,
    output logic               llbit_o
);

    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;
    logic              whilo_q, whilo_d;
    logic              llbit_we_q, llbit_we_d;
    logic              llbit_value_q, llbit_value_d;

    logic bubble;
    logic capture;

    assign bubble  = stall[STALL_MEM] == Stop && stall[STALL_WB] == NoStop;
    assign capture = stall[STALL_MEM] == NoStop;

    always_comb begin
        waddr_d       = waddr_q;
        we_d          = we_q;
        wdata_d       = wdata_q;
        hi_d          = hi_q;
        lo_d          = lo_q;
        whilo_d       = whilo_q;
        llbit_we_d    = llbit_we_q;
        llbit_value_d = llbit_value_q;
        if (flush || bubble) begin
            waddr_d       = '0;
            we_d          = WriteDisable;
            wdata_d       = '0;
            hi_d          = '0;
            lo_d          = '0;
            whilo_d       = WriteDisable;
            llbit_we_d    = WriteDisable;
            llbit_value_d = 1'b0;
        end else if (capture) begin
            waddr_d       = mem_waddr;
            we_d          = mem_we;
            wdata_d       = mem_wdata;
            hi_d          = mem_hi;
            lo_d          = mem_lo;
            whilo_d       = mem_whilo;
            llbit_we_d    = mem_llbit_we;
            llbit_value_d = mem_llbit_value;
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            waddr_q       <= '0;
            we_q          <= WriteDisable;
            wdata_q       <= '0;
            hi_q          <= '0;
            lo_q          <= '0;
            whilo_q       <= WriteDisable;
            llbit_we_q    <= WriteDisable;
            llbit_value_q <= 1'b0;
        end else begin
            waddr_q       <= waddr_d;
            we_q          <= we_d;
            wdata_q       <= wdata_d;
            hi_q          <= hi_d;
            lo_q          <= lo_d;
            whilo_q       <= whilo_d;
            llbit_we_q    <= llbit_we_d;
            llbit_value_q <= llbit_value_d;
        end
    end

    assign wb_waddr = waddr_q;
    assign wb_we    = we_q;
    assign wb_wdata = wdata_q;
    assign wb_hi    = hi_q;
    assign wb_lo    = lo_q;
    assign wb_whilo = whilo_q;

    // A held WB stage keeps its LLbit write pending instead of committing it.
    llbit_reg u_llbit (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .commit_en  (stall[STALL_WB] == NoStop),
        .pend_we    (llbit_we_q),
        .pend_value (llbit_value_q),
        .llbit_o    (llbit_o)
    );

endmodule

// File: tb/tb_mem_wb.sv
// Directed self-checking bench for the MEM/WB pipeline register.
// Each task drives one scenario and checks outputs inline.
module tb_mem_wb;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [4:0]  mem_waddr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_hi;
    logic [31:0] mem_lo;
    logic        mem_whilo;
    logic        mem_llbit_we;
    logic        mem_llbit_value;
    logic [4:0]  wb_waddr;
    logic        wb_we;
    logic [31:0] wb_wdata;
    logic [31:0] wb_hi;
    logic [31:0] wb_lo;
    logic        wb_whilo;
    logic        llbit_o;

    int n_checks;
    int n_fails;

    mem_wb #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .flush           (flush),
        .mem_waddr       (mem_waddr),
        .mem_we          (mem_we),
        .mem_wdata       (mem_wdata),
        .mem_hi          (mem_hi),
        .mem_lo          (mem_lo),
        .mem_whilo       (mem_whilo),
        .mem_llbit_we    (mem_llbit_we),
        .mem_llbit_value (mem_llbit_value),
        .wb_waddr        (wb_waddr),
        .wb_we           (wb_we),
        .wb_wdata        (wb_wdata),
        .wb_hi           (wb_hi),
        .wb_lo           (wb_lo),
        .wb_whilo        (wb_whilo),
        .llbit_o         (llbit_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stall           = 6'b0;
        flush           = 1'b0;
        mem_waddr       = 5'd0;
        mem_we          = 1'b0;
        mem_wdata       = 32'h0;
        mem_hi          = 32'h0;
        mem_lo          = 32'h0;
        mem_whilo       = 1'b0;
        mem_llbit_we    = 1'b0;
        mem_llbit_value = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst             = 1'b1;
        mem_waddr       = 5'd9;
        mem_we          = 1'b1;
        mem_wdata       = 32'hA5A5A5A5;
        mem_hi          = 32'h11;
        mem_lo          = 32'h22;
        mem_whilo       = 1'b1;
        mem_llbit_we    = 1'b1;
        mem_llbit_value = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({wb_waddr, wb_we, wb_whilo} !== 7'b0) begin
            n_fails++;
            $display("FAIL reset_ctl: got %h want 0",
                     {wb_waddr, wb_we, wb_whilo});
        end
        n_checks++;
        if ({wb_wdata, wb_hi, wb_lo} !== 96'h0) begin
            n_fails++;
            $display("FAIL reset_data: got %h want 0",
                     {wb_wdata, wb_hi, wb_lo});
        end
        n_checks++;
        if (llbit_o !== 1'b0) begin
            n_fails++;
            $display("FAIL reset_llbit: got %b want 0", llbit_o);
        end
        clear_inputs();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_capture();
        mem_waddr = 5'd3;
        mem_we    = 1'b1;
        mem_wdata = 32'hDEADBEEF;
        tick();
        n_checks++;
        if (wb_waddr !== 5'd3 || wb_we !== 1'b1) begin
            n_fails++;
            $display("FAIL capture_ctl: got %0d/%b want 3/1",
                     wb_waddr, wb_we);
        end
        n_checks++;
        if (wb_wdata !== 32'hDEADBEEF) begin
            n_fails++;
            $display("FAIL capture_data: got %h want deadbeef",
                     wb_wdata);
        end
        // Register 0 writes are not gated here.
        mem_waddr = 5'd0;
        mem_wdata = 32'h0BADF00D;
        tick();
        n_checks++;
        if (wb_we !== 1'b1 || wb_waddr !== 5'd0 ||
            wb_wdata !== 32'h0BADF00D) begin
            n_fails++;
            $display("FAIL capture_r0: got %b/%0d/%h want 1/0/0badf00d",
                     wb_we, wb_waddr, wb_wdata);
        end
    endtask

    task automatic test_bubble();
        mem_waddr = 5'd5;
        mem_we    = 1'b1;
        mem_wdata = 32'hCAFEF00D;
        stall     = 6'b011111;
        tick();
        n_checks++;
        if (wb_we !== 1'b0 || wb_wdata !== 32'h0 || wb_waddr !== 5'd0) begin
            n_fails++;
            $display("FAIL bubble: got %b/%h/%0d want 0/0/0",
                     wb_we, wb_wdata, wb_waddr);
        end
        clear_inputs();
    endtask

    task automatic test_hold();
        mem_waddr = 5'd4;
        mem_we    = 1'b1;
        mem_wdata = 32'h12345678;
        tick();
        stall     = 6'b111111;
        mem_waddr = 5'd6;
        mem_wdata = 32'h87654321;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (wb_waddr !== 5'd4 || wb_we !== 1'b1 ||
                wb_wdata !== 32'h12345678) begin
                n_fails++;
                $display("FAIL hold_%0d: got %0d/%b/%h want 4/1/12345678",
                         i, wb_waddr, wb_we, wb_wdata);
            end
        end
        stall = 6'b0;
        tick();
        n_checks++;
        if (wb_waddr !== 5'd6 || wb_wdata !== 32'h87654321) begin
            n_fails++;
            $display("FAIL hold_release: got %0d/%h want 6/87654321",
                     wb_waddr, wb_wdata);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_llsc();
        mem_llbit_we    = 1'b1;
        mem_llbit_value = 1'b1;
        tick();
        n_checks++;
        if (llbit_o !== 1'b1) begin
            n_fails++;
            $display("FAIL ll_bypass: got %b want 1", llbit_o);
        end
        mem_llbit_we    = 1'b0;
        mem_llbit_value = 1'b0;
        tick();
        n_checks++;
        if (llbit_o !== 1'b1) begin
            n_fails++;
            $display("FAIL ll_commit: got %b want 1", llbit_o);
        end
        mem_llbit_we = 1'b1;
        tick();
        n_checks++;
        if (llbit_o !== 1'b0) begin
            n_fails++;
            $display("FAIL sc_bypass: got %b want 0", llbit_o);
        end
        mem_llbit_we = 1'b0;
        tick();
        n_checks++;
        if (llbit_o !== 1'b0) begin
            n_fails++;
            $display("FAIL sc_commit: got %b want 0", llbit_o);
        end
    endtask

    task automatic test_flush();
        mem_llbit_we    = 1'b1;
        mem_llbit_value = 1'b1;
        tick();
        clear_inputs();
        tick();
        n_checks++;
        if (llbit_o !== 1'b1) begin
            n_fails++;
            $display("FAIL flush_setup: got %b want 1", llbit_o);
        end
        mem_waddr = 5'd7;
        mem_we    = 1'b1;
        mem_wdata = 32'h77777777;
        flush     = 1'b1;
        #1;
        n_checks++;
        if (llbit_o !== 1'b0) begin
            n_fails++;
            $display("FAIL flush_comb: got %b want 0", llbit_o);
        end
        tick();
        clear_inputs();
        #1;
        n_checks++;
        if (wb_we !== 1'b0 || wb_wdata !== 32'h0 || llbit_o !== 1'b0) begin
            n_fails++;
            $display("FAIL flush_after: got %b/%h/%b want 0/0/0",
                     wb_we, wb_wdata, llbit_o);
        end
    endtask

    task automatic test_hilo_flush();
        mem_whilo = 1'b1;
        mem_hi    = 32'h1;
        mem_lo    = 32'h2;
        tick();
        n_checks++;
        if (wb_whilo !== 1'b1 || wb_hi !== 32'h1 || wb_lo !== 32'h2) begin
            n_fails++;
            $display("FAIL hilo_capture: got %b/%h/%h want 1/1/2",
                     wb_whilo, wb_hi, wb_lo);
        end
        flush = 1'b1;
        tick();
        n_checks++;
        if (wb_whilo !== 1'b0 || wb_hi !== 32'h0 || wb_lo !== 32'h0) begin
            n_fails++;
            $display("FAIL hilo_flush: got %b/%h/%h want 0/0/0",
                     wb_whilo, wb_hi, wb_lo);
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid_stall();
        mem_waddr       = 5'd12;
        mem_we          = 1'b1;
        mem_wdata       = 32'h55AA55AA;
        mem_llbit_we    = 1'b1;
        mem_llbit_value = 1'b1;
        tick();
        stall = 6'b111111;
        tick();
        rst = 1'b1;
        tick();
        n_checks++;
        if (wb_we !== 1'b0 || wb_waddr !== 5'd0 ||
            wb_wdata !== 32'h0 || llbit_o !== 1'b0) begin
            n_fails++;
            $display("FAIL rst_stall: got %b/%0d/%h/%b want 0/0/0/0",
                     wb_we, wb_waddr, wb_wdata, llbit_o);
        end
        rst = 1'b0;
        clear_inputs();
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst      = 1'b1;
        clear_inputs();
        test_reset();
        test_capture();
        test_bubble();
        test_hold();
        test_llsc();
        test_flush();
        test_hilo_flush();
        test_reset_mid_stall();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/mem_wb.md
Name: mem_wb

Overview:
- MEM/WB pipeline register of the 5-stage core.
- Captures MEM-stage results and drives the register file write port (waddr/wdata/we) and the HI/LO write port.
- Owns the LLbit register used by ll/sc, and forwards the pending LLbit value back to the MEM stage.
- Obeys the core-wide 6-bit stall vector and the exception flush.

Parameters:
- DATA_W, 32, width of general/HI/LO data.
- ADDR_W, 5, register address width (2^ADDR_W registers).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- stall  in  6  per-stage stall vector; bit i=1 stalls stage i (0=PC … 4=MEM, 5=WB).
- flush  in  1  exception flush, 1-cycle pulse.
- mem_waddr  in  ADDR_W  destination register from MEM.
- mem_we  in  1  register write enable from MEM.
- mem_wdata  in  DATA_W  result from MEM.
- mem_hi, mem_lo  in  DATA_W  HI/LO results.
- mem_whilo  in  1  HI/LO write enable.
- mem_llbit_we  in  1  LLbit write request (ll sets 1, sc sets 0).
- mem_llbit_value  in  1  LLbit value to write.
- wb_waddr  out  ADDR_W  to regfile waddr.
- wb_we  out  1  to regfile we.
- wb_wdata  out  DATA_W  to regfile wdata.
- wb_hi, wb_lo  out  DATA_W  to HI/LO unit.
- wb_whilo  out  1  HI/LO write enable.
- llbit_o  out  1  forwarded LLbit for MEM-stage sc evaluation.

Behaviour:
- All state updates on posedge clk. Priority is rst > flush > bubble > capture > hold.
- **rst=1:**
  - All wb_* outputs become 0.
  - The internal LLbit register becomes 0.
  - The pending LLbit request (wb_llbit_we/wb_llbit_value, internal) becomes 0.
- **flush=1:**
  - Insert a bubble: all wb_* outputs and the pending LLbit request become 0.
  - LLbit register becomes 0. eret/exception breaks any ll/sc pair.
- **Bubble:** when stall[4]=1 and stall[5]=0, all wb_* outputs and the pending LLbit request become 0. MEM stalled, WB runs.
- **Capture:** when stall[4]=0, all mem_* inputs are registered, including mem_llbit_we/mem_llbit_value. Latency is exactly 1 cycle.
- **Hold:** when stall[4]=1 and stall[5]=1, all registered values hold.
- **LLbit register update** (same edge as the pipeline register):
  - rst → 0.
  - Else flush → 0.
  - Else, if the pending wb_llbit_we=1 → wb_llbit_value.
  - Else hold.
  - A held stage (stall[5]=1) does not commit LLbit until released.
- **llbit_o (combinational):**
  - flush=1 → 0.
  - Else, if the pending wb_llbit_we=1 → wb_llbit_value (bypass of the not-yet-committed write).
  - Else → LLbit register.
- wb_we is not gated on wb_waddr=0. The regfile itself ignores writes to register 0.
- No width conversion; data passes bit-exact.
- A flush in the same cycle as a capture discards the capture.
- Reset asserted mid-stall clears state regardless of the stall vector.

Decomposition:
- Shared defines package:
  - RstEnable, WriteEnable, Stop/NoStop.
  - ZeroWord, RegAddrBus, RegBus.
  - Stall vector width constant (6).
- One natural sub-module: llbit_reg (LLbit register plus forwarding mux), instantiated inside mem_wb.
- The pipeline register stays in the top module.

Test Plan:
- rst=1 with nonzero mem_* inputs, then release → all wb_*=0 and llbit_o=0 during reset.
- Capture: mem_waddr=5'd3, mem_we=1, mem_wdata=32'hDEADBEEF, stall=0 → next cycle wb_waddr=3, wb_we=1, wb_wdata=32'hDEADBEEF; regfile read of r3 in that cycle returns 32'hDEADBEEF via its bypass.
- Bubble and hold:
  - stall=6'b011111 → wb_we=0, wb_wdata=0 next cycle.
  - stall=6'b111111 after a capture of r4=32'h12345678 → values hold for 3 cycles, then advance when stall clears.
- ll/sc:
  - ll captured (mem_llbit_we=1, value=1) → llbit_o=1 in the WB cycle (bypass) and after commit.
  - A following sc with mem_llbit_we=1, value=0 → llbit_o=0 one cycle later.
- flush while the LLbit register=1 and a capture with mem_we=1 is pending → next cycle wb_we=0, llbit_o=0, LLbit register=0.
- mem_whilo=1, mem_hi=32'h1, mem_lo=32'h2, then flush on the following cycle → wb_whilo=1/hi=1/lo=2 for one cycle, then all 0.
